// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - IF/ID pipeline register with branch/jump decode and next-PC select
//
// Purpose:
//   Holds the IF/ID pipeline register and decodes the latched instruction.
//   The decode resolves the delayed-branch / jump decision in D and selects
//   the next fetch PC. It also keeps free-running stall and redirect counters.
//
// Ports:
//   Clk        in   1   rising-edge clock
//   Rst        in   1   synchronous active-high reset (priority over Stall)
//   Stall      in   1   1 = freeze F and D
//   PC_F       in  32   current fetch PC
//   Instr_F    in  32   instruction word at PC_F
//   RS_D       in  32   forwarded rs value for Instr_D
//   RT_D       in  32   forwarded rt value for Instr_D
//   NPC        out 32   next fetch PC
//   PC_We      out  1   fetch-PC write enable (~Stall)
//   Instr_D    out 32   latched instruction
//   PC_D       out 32   latched PC
//   PC8_D      out 32   link value PC_D + 8
//   Link_D     out  1   Instr_D writes $31
//   Taken_D    out  1   Instr_D redirects fetch
//   Stall_cnt  out 32   stall-cycle counter
//   Redir_cnt  out 32   redirect counter

module fetch_decode_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic [31:0] PC_F,
    input  logic [31:0] Instr_F,
    input  logic [31:0] RS_D,
    input  logic [31:0] RT_D,
    output logic [31:0] NPC,
    output logic        PC_We,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PC8_D,
    output logic        Link_D,
    output logic        Taken_D,
    output logic [31:0] Stall_cnt,
    output logic [31:0] Redir_cnt
);

    localparam logic [5:0]  OP_SPECIAL = 6'b000000;
    localparam logic [5:0]  OP_REGIMM  = 6'b000001;
    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_JAL     = 6'b000011;
    localparam logic [5:0]  OP_BEQ     = 6'b000100;
    localparam logic [5:0]  OP_BNE     = 6'b000101;
    localparam logic [4:0]  RT_BGEZAL  = 5'b10001;
    localparam logic [5:0]  FN_JR      = 6'b001000;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;

    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redir_cnt;

    logic [5:0]  w_op;
    logic [4:0]  w_rt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_idx;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_link;

    assign w_op    = r_instr_d[31:26];
    assign w_rt    = r_instr_d[20:16];
    assign w_funct = r_instr_d[5:0];
    assign w_imm   = r_instr_d[15:0];
    assign w_idx   = r_instr_d[25:0];

    // Sign-extended word offset; the add wraps modulo 2^32 by width.
    assign w_br_offset = {{14{w_imm[15]}}, w_imm, 2'b00};
    assign w_br_target = r_pc_d + 32'd4 + w_br_offset;
    assign w_j_target  = {r_pc_d[31:28], w_idx, 2'b00};
    assign w_seq_pc    = PC_F + 32'd4;

    // Decision is recomputed every cycle, including during a stall, so the
    // value seen in the first unstalled cycle uses the freshest forwarded data.
    always_comb begin
        w_taken  = 1'b0;
        w_link   = 1'b0;
        w_target = w_br_target;
        case (w_op)
            OP_BEQ: begin
                w_taken = (RS_D == RT_D);
            end
            OP_BNE: begin
                w_taken = (RS_D != RT_D);
            end
            OP_REGIMM: begin
                if (w_rt == RT_BGEZAL) begin
                    w_taken = ~RS_D[31];
                    w_link  = 1'b1;
                end
            end
            OP_J: begin
                w_taken  = 1'b1;
                w_target = w_j_target;
            end
            OP_JAL: begin
                w_taken  = 1'b1;
                w_link   = 1'b1;
                w_target = w_j_target;
            end
            OP_SPECIAL: begin
                if (w_funct == FN_JR) begin
                    w_taken  = 1'b1;
                    w_target = RS_D;
                end
            end
            default: begin
                w_taken = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_instr_d   <= 32'h0000_0000;
            r_pc_d      <= RESET_PC;
            r_stall_cnt <= 32'h0000_0000;
            r_redir_cnt <= 32'h0000_0000;
        end else if (Stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_instr_d <= Instr_F;
            r_pc_d    <= PC_F;
            if (w_taken) begin
                r_redir_cnt <= r_redir_cnt + 32'd1;
            end
        end
    end

    assign NPC       = w_taken ? w_target : w_seq_pc;
    assign PC_We     = ~Stall;
    assign Instr_D   = r_instr_d;
    assign PC_D      = r_pc_d;
    assign PC8_D     = r_pc_d + 32'd8;
    assign Link_D    = w_link;
    assign Taken_D   = w_taken;
    assign Stall_cnt = r_stall_cnt;
    assign Redir_cnt = r_redir_cnt;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - self-checking bench for fetch_decode_stage

module tb_fetch_decode_stage;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall = 1'b0;
    logic [31:0] PC_F = 32'h0;
    logic [31:0] Instr_F = 32'h0;
    logic [31:0] RS_D = 32'h0;
    logic [31:0] RT_D = 32'h0;
    logic [31:0] NPC;
    logic        PC_We;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic        Link_D;
    logic        Taken_D;
    logic [31:0] Stall_cnt;
    logic [31:0] Redir_cnt;

    int checks = 0;
    int errors = 0;

    fetch_decode_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .PC_F(PC_F), .Instr_F(Instr_F),
        .RS_D(RS_D), .RT_D(RT_D), .NPC(NPC), .PC_We(PC_We), .Instr_D(Instr_D),
        .PC_D(PC_D), .PC8_D(PC8_D), .Link_D(Link_D), .Taken_D(Taken_D),
        .Stall_cnt(Stall_cnt), .Redir_cnt(Redir_cnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input logic stall_during);
        Rst = 1'b1;
        Stall = stall_during;
        tick();
        Rst = 1'b0;
        Stall = 1'b0;
    endtask

    task automatic load_d(input logic [31:0] instr, input logic [31:0] pc);
        Stall = 1'b0;
        Instr_F = instr;
        PC_F = pc;
        tick();
    endtask

    // Reference semantics of the instruction in D, stated from the ISA rules.
    task automatic ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] pcf,
                              output logic taken, output logic link, output logic [31:0] npc);
        int unsigned op, rtf, fn;
        logic [31:0] br, jt, off;
        op  = instr >> 26;
        rtf = (instr >> 16) & 32'h1F;
        fn  = instr & 32'h3F;
        off = {{16{instr[15]}}, instr[15:0]} * 32'd4;
        br  = pc + 32'd4 + off;
        jt  = (pc & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        taken = 1'b0;
        link  = 1'b0;
        npc   = pcf + 32'd4;
        if (op == 4 && rs == rt) begin taken = 1'b1; npc = br; end
        if (op == 5 && rs != rt) begin taken = 1'b1; npc = br; end
        if (op == 1 && rtf == 17) begin
            link = 1'b1;
            if ($signed(rs) >= 0) begin taken = 1'b1; npc = br; end
        end
        if (op == 2) begin taken = 1'b1; npc = jt; end
        if (op == 3) begin taken = 1'b1; link = 1'b1; npc = jt; end
        if (op == 0 && fn == 8) begin taken = 1'b1; npc = rs; end
    endtask

    task automatic test_reset();
        PC_F = 32'h0000_1230;
        do_reset(1'b1);
        checks++; if (Instr_D !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", Instr_D); end
        checks++; if (PC_D !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want 00003000", PC_D); end
        checks++; if (PC8_D !== 32'h3008) begin errors++; $display("FAIL reset_pc8: got %h want 00003008", PC8_D); end
        checks++; if (Taken_D !== 1'b0 || Link_D !== 1'b0) begin errors++; $display("FAIL reset_flags: got taken=%b link=%b want 0 0", Taken_D, Link_D); end
        checks++; if (NPC !== 32'h1234) begin errors++; $display("FAIL reset_npc: got %h want 00001234", NPC); end
        checks++; if (Stall_cnt !== 32'h0 || Redir_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h %h want 0 0", Stall_cnt, Redir_cnt); end
    endtask

    task automatic test_nop_fetch();
        do_reset(1'b0);
        load_d(32'h0, 32'h3000);
        checks++; if (PC_D !== 32'h3000) begin errors++; $display("FAIL nop_pc: got %h want 00003000", PC_D); end
        checks++; if (NPC !== 32'h3004 || Taken_D !== 1'b0) begin errors++; $display("FAIL nop_npc: got %h taken=%b want 00003004 0", NPC, Taken_D); end
        checks++; if (Redir_cnt !== 32'h0 || PC_We !== 1'b1) begin errors++; $display("FAIL nop_redir: got %h we=%b want 0 1", Redir_cnt, PC_We); end
    endtask

    task automatic test_beq();
        load_d({6'b000100, 5'd1, 5'd2, 16'hFFFF}, 32'h3010);
        PC_F = 32'h3014;
        RS_D = 32'd5; RT_D = 32'd5;
        #1;
        checks++; if (Taken_D !== 1'b1 || NPC !== 32'h3010) begin errors++; $display("FAIL beq_taken: got %b %h want 1 00003010", Taken_D, NPC); end
        RT_D = 32'd6;
        #1;
        checks++; if (Taken_D !== 1'b0 || NPC !== 32'h3018) begin errors++; $display("FAIL beq_not_taken: got %b %h want 0 00003018", Taken_D, NPC); end
    endtask

    task automatic test_bgezal();
        load_d({6'b000001, 5'd3, 5'b10001, 16'h0004}, 32'h3020);
        PC_F = 32'h3024;
        RS_D = 32'h8000_0000;
        #1;
        checks++; if (Taken_D !== 1'b0 || Link_D !== 1'b1 || PC8_D !== 32'h3028) begin errors++; $display("FAIL bgezal_neg: got %b %b %h want 0 1 00003028", Taken_D, Link_D, PC8_D); end
        RS_D = 32'h0;
        #1;
        checks++; if (Taken_D !== 1'b1 || NPC !== 32'h3034 || Link_D !== 1'b1) begin errors++; $display("FAIL bgezal_pos: got %b %h %b want 1 00003034 1", Taken_D, NPC, Link_D); end
    endtask

    task automatic test_jr_stall();
        logic [31:0] jr;
        jr = {6'b000000, 5'd4, 15'd0, 6'b001000};
        do_reset(1'b0);
        RS_D = 32'h3100;
        load_d(jr, 32'h3050);
        checks++; if (Taken_D !== 1'b1 || NPC !== 32'h3100) begin errors++; $display("FAIL jr_target: got %b %h want 1 00003100", Taken_D, NPC); end
        Stall = 1'b1;
        RS_D = 32'h3200;
        Instr_F = 32'hDEAD_BEEF;
        PC_F = 32'h3054;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (PC_We !== 1'b0) begin errors++; $display("FAIL jr_stall_we: got %b want 0", PC_We); end
        checks++; if (Instr_D !== jr || PC_D !== 32'h3050) begin errors++; $display("FAIL jr_stall_hold: got %h %h want %h 00003050", Instr_D, PC_D, jr); end
        checks++; if (Stall_cnt !== 32'd3 || Redir_cnt !== 32'd0) begin errors++; $display("FAIL jr_stall_cnt: got %0d %0d want 3 0", Stall_cnt, Redir_cnt); end
        Stall = 1'b0;
        #1;
        checks++; if (NPC !== 32'h3200) begin errors++; $display("FAIL jr_release_npc: got %h want 00003200", NPC); end
        tick();
        checks++; if (Redir_cnt !== 32'd1) begin errors++; $display("FAIL jr_redir: got %0d want 1", Redir_cnt); end
    endtask

    task automatic test_jal_reset();
        load_d({6'b000011, 26'h0000C10}, 32'h3040);
        checks++; if (NPC !== 32'h3040 || Link_D !== 1'b1 || PC8_D !== 32'h3048) begin errors++; $display("FAIL jal: got %h %b %h want 00003040 1 00003048", NPC, Link_D, PC8_D); end
        do_reset(1'b1);
        checks++; if (Instr_D !== 32'h0 || PC_D !== 32'h3000) begin errors++; $display("FAIL jal_reset_state: got %h %h want 0 00003000", Instr_D, PC_D); end
        checks++; if (Stall_cnt !== 32'h0 || Redir_cnt !== 32'h0) begin errors++; $display("FAIL jal_reset_cnt: got %h %h want 0 0", Stall_cnt, Redir_cnt); end
    endtask

    task automatic test_stall_wrap();
        do_reset(1'b0);
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_cnt;
        #1;
        checks++; if (Stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", Stall_cnt); end
        Stall = 1'b1;
        tick();
        checks++; if (Stall_cnt !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", Stall_cnt); end
        tick();
        checks++; if (Stall_cnt !== 32'h1) begin errors++; $display("FAIL wrap_one: got %h want 00000001", Stall_cnt); end
        Stall = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] m_instr, m_pc, m_sc, m_rc, e_npc, ins;
        logic        e_taken, e_link;
        int          bad;
        do_reset(1'b0);
        m_instr = 32'h0; m_pc = 32'h3000; m_sc = 0; m_rc = 0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0: ins = {6'b000100, 10'($urandom), 16'($urandom)};
                1: ins = {6'b000101, 10'($urandom), 16'($urandom)};
                2: ins = {6'b000001, 5'($urandom), 5'b10001, 16'($urandom)};
                3: ins = {6'b000010, 26'($urandom)};
                4: ins = {6'b000011, 26'($urandom)};
                5: ins = {6'b000000, 20'($urandom), 6'b001000};
                6: ins = {6'b000001, 5'($urandom), 5'b00001, 16'($urandom)};
                default: ins = $urandom;
            endcase
            Instr_F = ins;
            PC_F    = $urandom;
            RS_D    = $urandom;
            RT_D    = ($urandom_range(0, 2) == 0) ? RS_D : $urandom;
            if ($urandom_range(0, 3) == 0) RS_D[31] = ~RS_D[31];
            Stall   = ($urandom_range(0, 3) == 0);
            #1;
            ref_decode(m_instr, m_pc, RS_D, RT_D, PC_F, e_taken, e_link, e_npc);
            bad = 0;
            checks++;
            if (Instr_D !== m_instr || PC_D !== m_pc || PC8_D !== m_pc + 32'd8) bad = 1;
            if (Taken_D !== e_taken || Link_D !== e_link || NPC !== e_npc) bad = 1;
            if (PC_We !== ~Stall || Stall_cnt !== m_sc || Redir_cnt !== m_rc) bad = 1;
            if (bad != 0) begin
                errors++;
                $display("FAIL random[%0d]: got instr=%h pc=%h taken=%b link=%b npc=%h sc=%0d rc=%0d want instr=%h pc=%h taken=%b link=%b npc=%h sc=%0d rc=%0d",
                         n, Instr_D, PC_D, Taken_D, Link_D, NPC, Stall_cnt, Redir_cnt,
                         m_instr, m_pc, e_taken, e_link, e_npc, m_sc, m_rc);
            end
            if (Stall) begin
                m_sc = m_sc + 1;
            end else begin
                if (e_taken) m_rc = m_rc + 1;
                m_instr = Instr_F;
                m_pc    = PC_F;
            end
            tick();
        end
        Stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nop_fetch();
        test_beq();
        test_bgezal();
        test_jr_stall();
        test_jal_reset();
        test_stall_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 Clk  in  1  rising-edge clock.
REQ-002 Rst  in  1  synchronous, active-high reset; Clk is the clock.
REQ-003 Stall  in  1  from hazard unit; 1 = freeze F and D.
REQ-004 PC_F  in  32  current fetch PC from fetch unit.
REQ-005 Instr_F  in  32  instruction word at PC_F.
REQ-006 RS_D  in  32  forwarded rs value for Instr_D.
REQ-007 RT_D  in  32  forwarded rt value for Instr_D.
REQ-008 NPC  out  32  next fetch PC, to fetch unit.
REQ-009 PC_We  out  1  fetch-PC write enable, equal to ~Stall.
REQ-010 Instr_D  out  32  IF/ID latched instruction.
REQ-011 PC_D  out  32  IF/ID latched PC.
REQ-012 PC8_D  out  32  PC_D + 8, the link value.
REQ-013 Link_D  out  1  Instr_D writes $31 (jal, bgezal).
REQ-014 Taken_D  out  1  Instr_D redirects fetch.
REQ-015 Stall_cnt  out  32  stall-cycle counter.
REQ-016 Redir_cnt  out  32  redirect counter.

Function
REQ-017 IF/ID register: when Stall=0 at a rising edge, Instr_D<=Instr_F and PC_D<=PC_F; when Stall=1, both hold.
REQ-018 Decode is combinational from Instr_D. Field slices: op=[31:26], rt=[20:16], funct=[5:0], imm=[15:0], idx=[25:0].
REQ-019 Recognised opcodes: beq op=000100; bne op=000101; bgezal op=000001 with rt=10001; j op=000010; jal op=000011; jr op=000000 with funct=001000.
REQ-020 Branch target is PC_D+4+(sign-extended imm<<2), using modulo-2^32 arithmetic.
REQ-021 Jump target is {PC_D[31:28], idx, 2'b00}. The jr target is RS_D, used unmodified.
REQ-022 Taken_D conditions:
- beq: RS_D==RT_D.
- bne: RS_D!=RT_D.
- bgezal: RS_D signed >= 0 (RS_D[31]==0).
- j, jal, jr: always.
- All other opcodes: 0.
REQ-023 NPC selection: Taken_D=1 gives the target for the decoded instruction; Taken_D=0 gives PC_F+4.
REQ-024 Branches are delayed. The instruction in F when a branch is in D (the delay slot) always proceeds, and no flush exists.
REQ-025 Link_D=1 for jal always and for bgezal regardless of the branch outcome. PC8_D=PC_D+8 always.
REQ-026 While Stall=1:
- PC_We=0, so NPC is ignored downstream.
- Taken_D/NPC keep being recomputed from the current RS_D/RT_D.
- The decision is final only in the first cycle with Stall=0.
REQ-027 Stall_cnt increments by 1 at each edge with Stall=1, wrapping 0xFFFFFFFF->0.
REQ-028 Redir_cnt increments at each edge with Stall=0 and Taken_D=1, and wraps.
REQ-029 Unknown opcodes are treated as non-control: Taken_D=0 and Link_D=0, with no error signalling.

Reset
REQ-030 While Rst=1 at an edge, the following load regardless of Stall: Instr_D=0x00000000 (nop), PC_D=0x00003000, Stall_cnt=0, Redir_cnt=0.
REQ-031 Immediately after reset, the outputs are: PC8_D=0x00003008, Taken_D=0, Link_D=0, NPC=PC_F+4.
REQ-032 Rst has priority over Stall. Reset mid-stall discards the held instruction.

Verification
REQ-033 Reset, then Stall=0, PC_F=0x3000, Instr_F=nop for one edge -> PC_D=0x3000, NPC=0x3004, Taken_D=0, Redir_cnt=0.
REQ-034 beq in D at PC_D=0x3010 with imm=0xFFFF, RS_D=RT_D=5 -> Taken_D=1, NPC=0x3010; with RT_D=6 -> NPC=PC_F+4.
REQ-035 bgezal at PC_D=0x3020 with imm=0x0004:
- RS_D=0x80000000 -> Taken_D=0, Link_D=1, PC8_D=0x3028.
- RS_D=0 -> Taken_D=1, NPC=0x3034.
REQ-036 jr in D with RS_D=0x3100, then Stall=1 for 3 edges while RS_D changes to 0x3200 -> PC_We=0, Instr_D/PC_D held, Stall_cnt=3. After release, NPC=0x3200 and Redir_cnt increments once.
REQ-037 jal in D, PC_D=0x3040, idx=0x0000C10 -> NPC=0x00003040, Link_D=1, PC8_D=0x3048. Assert Rst with Stall=1 the same cycle -> Instr_D=0, PC_D=0x3000, both counters 0.
REQ-038 Preload Stall_cnt to 0xFFFFFFFF by holding Stall (or by a force), then one more Stall edge -> Stall_cnt=0.
